// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants and types for the sequential ALU.
// Opcodes, condition codes, shifter encodings, FSM states and flag bit
// positions. The DIV state exists only when ALU_SEQ_DIV_EN is defined.
package alu_seq_pkg;

    // Opcodes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_ORR  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_MOVI = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_UDIV = 4'b1111;

    // Condition codes; 1001-1111 never pass
    localparam logic [3:0] CC_AL = 4'b0000;
    localparam logic [3:0] CC_EQ = 4'b0001;
    localparam logic [3:0] CC_GT = 4'b0010;
    localparam logic [3:0] CC_LT = 4'b0011;
    localparam logic [3:0] CC_GE = 4'b0100;
    localparam logic [3:0] CC_LE = 4'b0101;
    localparam logic [3:0] CC_HI = 4'b0110;
    localparam logic [3:0] CC_LO = 4'b0111;
    localparam logic [3:0] CC_HS = 4'b1000;

    // Operand-B shifter control
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSR  = 2'b01;
    localparam logic [1:0] SH_LSL  = 2'b10;
    localparam logic [1:0] SH_ROR  = 2'b11;

    // Bit positions inside the {N,Z,C,V} flag register
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

`ifdef ALU_SEQ_DIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    // Evaluate a condition code against a stored {N,Z,C,V} value
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[FLAG_N];
        z = f[FLAG_Z];
        c = f[FLAG_C];
        v = f[FLAG_V];
        case (cc)
            CC_AL:   cond_pass = 1'b1;
            CC_EQ:   cond_pass = z;
            CC_GT:   cond_pass = !z && (n == v);
            CC_LT:   cond_pass = (n != v);
            CC_GE:   cond_pass = (n == v);
            CC_LE:   cond_pass = z || (n != v);
            CC_HI:   cond_pass = c && !z;
            CC_LO:   cond_pass = !c;
            CC_HS:   cond_pass = c;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: combinational operand-B pre-shifter.
// Ports: din (operand), sh_ctl (none/LSR/LSL/ROR), sh_amt (amount),
//        dout_c (shifted operand, combinational).
// WIDTH must be a power of two so the rotate can use modular shift amounts.
module alu_seq_shifter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sh_ctl,
    input  logic [SHW-1:0]   sh_amt,
    output logic [WIDTH-1:0] dout_c
);

    // Left shift by (-amt mod WIDTH) supplies the wrapped bits of a rotate;
    // amt=0 makes both halves equal to din, so ROR 0 is a pass-through.
    logic [SHW-1:0] neg_amt;
    assign neg_amt = SHW'(0) - sh_amt;

    always_comb begin
        dout_c = din;
        case (sh_ctl)
            SH_LSR:  dout_c = din >> sh_amt;
            SH_LSL:  dout_c = din << sh_amt;
            SH_ROR:  dout_c = (din >> sh_amt) | (din << neg_amt);
            default: dout_c = din;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with NZCV flag register, pre-shifter on
// operand B and an iterative shift-add multiplier (one bit per cycle).
// Ports: clk/rst (sync, active high); in_valid/in_ready, op, cond, s_bit,
//        op_a, op_b, sh_ctl, sh_amt, imm on the request side;
//        out_valid/out_ready, result, res_wr, flags, err on the result side.
// Macro ALU_SEQ_DIV_EN: opcode 1111 becomes an unsigned restoring divide
// (state DIV, same latency as MUL); otherwise 1111 is illegal.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [3:0]       cond,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       sh_ctl,
    input  logic [SHW-1:0]   sh_amt,
    input  logic [IMM_W-1:0] imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_wr,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned W1  = WIDTH + 1;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic             lat_s;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mul_nxt;
    logic [WIDTH-1:0] b_sh;
    logic             pass;

    // Single-cycle datapath outputs
    logic [W1-1:0]    sum_w;
    logic [W1-1:0]    dif_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_arith;
    logic             alu_legal;
    logic             alu_wr;

    alu_seq_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
        .din    (op_b),
        .sh_ctl (sh_ctl),
        .sh_amt (sh_amt),
        .dout_c (b_sh)
    );

    assign pass    = cond_pass(cond, flags);
    assign mul_nxt = acc + (mplier[0] ? mcand : '0);

`ifdef ALU_SEQ_DIV_EN
    // Restoring divide: remainder shifts in dividend MSBs kept in quot
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] dvsr;
    logic             div0;
    logic [W1-1:0]    rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;

    always_comb begin
        rem_sh   = {rem, quot[MSB]};
        div_ge   = (rem_sh >= {1'b0, dvsr});
        rem_nxt  = div_ge ? WIDTH'(rem_sh - {1'b0, dvsr}) : rem_sh[WIDTH-1:0];
        quot_nxt = {quot[MSB-1:0], div_ge};
    end
`endif

    // Single-cycle ops; C/V only meaningful when alu_arith is set
    always_comb begin
        sum_w     = {1'b0, op_a} + {1'b0, b_sh};
        dif_w     = {1'b0, op_a} + {1'b0, ~b_sh} + W1'(1);
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_arith = 1'b0;
        alu_legal = 1'b1;
        alu_wr    = 1'b1;
        case (op)
            OP_ADD: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_c     = sum_w[WIDTH];
                alu_v     = (op_a[MSB] == b_sh[MSB]) && (sum_w[MSB] != op_a[MSB]);
                alu_arith = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res   = dif_w[WIDTH-1:0];
                alu_c     = dif_w[WIDTH];
                alu_v     = (op_a[MSB] != b_sh[MSB]) && (dif_w[MSB] != op_a[MSB]);
                alu_arith = 1'b1;
                alu_wr    = (op != OP_CMP);
            end
            OP_ORR:  alu_res = op_a | b_sh;
            OP_AND:  alu_res = op_a & b_sh;
            OP_XOR:  alu_res = op_a ^ b_sh;
            OP_MOVI: alu_res = WIDTH'(imm);
            OP_MOV:  alu_res = b_sh;
            default: begin
                alu_legal = 1'b0;
                alu_wr    = 1'b0;
            end
        endcase
    end

    // Control FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            res_wr    <= 1'b0;
            err       <= 1'b0;
            flags     <= '0;
            cnt       <= '0;
            lat_s     <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
`ifdef ALU_SEQ_DIV_EN
            rem       <= '0;
            quot      <= '0;
            dvsr      <= '0;
            div0      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        lat_s <= s_bit;
                        cnt   <= '0;
                        if (!pass) begin
                            // Failed condition wins over opcode decoding
                            result    <= '0;
                            res_wr    <= 1'b0;
                            err       <= 1'b0;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= S_DONE;
                        end else if (op == OP_MUL) begin
                            acc      <= '0;
                            mcand    <= op_a;
                            mplier   <= b_sh;
                            in_ready <= 1'b0;
                            state    <= S_MUL;
`ifdef ALU_SEQ_DIV_EN
                        end else if (op == OP_UDIV) begin
                            rem      <= '0;
                            quot     <= op_a;
                            dvsr     <= b_sh;
                            div0     <= (b_sh == '0);
                            in_ready <= 1'b0;
                            state    <= S_DIV;
`endif
                        end else begin
                            result    <= alu_res;
                            res_wr    <= alu_wr;
                            err       <= !alu_legal;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= S_DONE;
                            if (alu_legal && (s_bit || op == OP_CMP)) begin
                                flags[FLAG_N] <= alu_res[MSB];
                                flags[FLAG_Z] <= (alu_res == '0);
                                if (alu_arith) begin
                                    flags[FLAG_C] <= alu_c;
                                    flags[FLAG_V] <= alu_v;
                                end
                            end
                        end
                    end
                end

                S_MUL: begin
                    acc    <= mul_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1)) begin
                        result    <= mul_nxt;
                        res_wr    <= 1'b1;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                        if (lat_s) begin
                            flags[FLAG_N] <= mul_nxt[MSB];
                            flags[FLAG_Z] <= (mul_nxt == '0);
                        end
                    end
                end

`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + SHW'(1);
                    if (cnt == SHW'(WIDTH - 1)) begin
                        result    <= div0 ? '1 : quot_nxt;
                        res_wr    <= 1'b1;
                        err       <= div0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                        if (lat_s && !div0) begin
                            flags[FLAG_N] <= quot_nxt[MSB];
                            flags[FLAG_Z] <= (quot_nxt == '0);
                        end
                    end
                end
`endif

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU; sits between register-read and writeback stages.
- Adds a registered NZCV flag register. Conditions are evaluated against the stored flags, ARM style, not by comparing operands.
- Adds a multi-cycle iterative multiplier, a pre-ALU shifter on operand B, and valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/result width (>=8, power of two).
- IMM_W, 16, immediate width; zero-extended to WIDTH by MOVI.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation.
- op  in  4  opcode.
- cond  in  4  condition code.
- s_bit  in  1  update flags on completion.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B (pre-shift).
- sh_ctl  in  2  shift type: 00 none, 01 LSR, 10 LSL, 11 ROR.
- sh_amt  in  SHW  shift amount.
- imm  in  IMM_W  immediate.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  result.
- res_wr  out  1  result must be written back (0 for CMP, condition-fail, illegal op).
- flags  out  4  current {N,Z,C,V} register.
- err  out  1  illegal opcode on this result.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; result=0; res_wr=0; err=0; flags=0. A reset mid-multiply aborts the operation with no flag update.
- FSM states: IDLE, MUL, DONE.
- Accept: only in IDLE, on in_valid&&in_ready. All inputs are latched on that edge. in_ready is low in MUL and DONE.
- Operand B after shift (B'):
  - LSR/LSL fill with zeros.
  - ROR rotates.
  - sh_amt=0 passes op_b unchanged.
- Condition, from the flags register at the accept edge:
  - 0000 AL; 0001 EQ Z; 0010 GT !Z&&N==V; 0011 LT N!=V; 0100 GE N==V; 0101 LE Z||N!=V; 0110 HI C&&!Z; 0111 LO !C; 1000 HS C.
  - 1001-1111 never pass.
- Condition fail: IDLE->DONE; result=0, res_wr=0, flags unchanged.
- Single-cycle ops, IDLE->DONE, out_valid at accept+1:
  - 0000 ADD A+B'.
  - 0001 SUB A-B'.
  - 0011 ORR.
  - 0100 AND.
  - 0101 XOR.
  - 0110 MOVI zext(imm).
  - 0111 MOV B'.
  - 1011 CMP (A-B', res_wr=0, flags always updated regardless of s_bit).
- MUL (0010): IDLE->MUL, shift-add one bit per cycle for WIDTH cycles, then ->DONE. out_valid at accept+WIDTH+1. Result is the low WIDTH bits of A*B'.
- Illegal opcode: ->DONE, result=0, res_wr=0, err=1, flags unchanged.
- Flag update at entry to DONE, when (s_bit||CMP) && condition passed:
  - N = result MSB; Z = result==0.
  - ADD: C = carry-out, V = signed overflow.
  - SUB/CMP: C = NOT borrow, V = signed overflow.
  - MUL and logic/moves: C,V unchanged.
- DONE: holds result/res_wr/err stable while out_valid=1. On out_valid&&out_ready -> IDLE; out_valid drops the next cycle.
- Throughput: at most one op per 2 cycles (single-cycle ops).
- flags is visible one cycle after the DONE entry edge. The next accepted op's condition sees the updated flags.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: opcode 1111 is UDIV, an unsigned restoring divide, 1 bit/cycle, via state DIV.
  - Latency matches MUL.
  - Divide by zero: result all-ones, err=1, flags unchanged.
  - Flag update: N,Z only.
- Undefined: 1111 is illegal (err=1); no DIV state is synthesised.

Decomposition:
- Package alu_seq_pkg holds: opcode constants, condition constants, sh_ctl encodings, FSM state enum, flag bit indices.
- One sub-module, alu_seq_shifter (combinational B' generation, parametrised WIDTH), reused by a future AGU.

Test Plan:
- Reset then ADD, WIDTH=32: A=0x7FFFFFFF, B=1, s_bit=1 -> result 0x80000000, out_valid at accept+1, flags N=1 Z=0 C=0 V=1.
- CMP A=5,B=5 then SUB A=9,B=2 cond=EQ -> flags Z=1 after CMP; SUB result 7, res_wr=1. Repeat with B=6 on CMP -> SUB condition fail, res_wr=0, result 0.
- MUL A=0xFFFF,B=0x10001, out_ready held low 3 cycles -> out_valid at accept+33; result 0xFFFFFFFF stable until handshake; in_ready low throughout.
- MOV op_b=0x80000001 sh_ctl=ROR sh_amt=1 -> 0xC0000000; LSR 4 of 0xF0000000 -> 0x0F000000; LSL 31 of 3 -> 0x80000000.
- Assert rst at MUL cycle 10 -> next cycle out_valid=0, in_ready=1, flags=0; new ADD 1+1 -> 2.
- Opcode 1100 -> err=1, res_wr=0, flags unchanged. With ALU_SEQ_DIV_EN: 100/7 -> 14; x/0 -> 0xFFFFFFFF, err=1.
